// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// helper that sizes the bit counter from the operand width.
package serial_adder_pkg;

    // Control states of the serial adder sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count 0..width-1; never less than one bit so that a
    // single-bit adder still has a legal counter vector.
    function automatic int cntWidth(input int width);
        int bits;
        bits = 0;
        while ((1 << bits) < width) begin
            bits = bits + 1;
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Start/busy/done handshake and operand/result bus of the serial adder.
// The master side issues operands, the slave side (the adder) returns the
// registered result and status.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start,
        output a,
        output b,
        output cin,
        input  busy,
        input  done,
        input  sum,
        input  cout,
        input  ovf
    );

    modport slave (
        input  start,
        input  a,
        input  b,
        input  cin,
        output busy,
        output done,
        output sum,
        output cout,
        output ovf
    );
endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full adder, the additive twin of the full-subtractor
// cells. Used as the single arithmetic stage of the serial adder.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    logic w_halfSum;

    assign w_halfSum = A ^ B;
    assign Sum       = w_halfSum ^ Cin;
    assign Cout      = (A & B) | (Cin & w_halfSum);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder. Operands are captured into shift registers on
// the accepting edge, then one bit per clock passes through a single full
// adder stage with the carry held in a flip-flop. After WIDTH bits the sum
// register holds the full result and done pulses for one cycle.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);

    localparam int                CNT_W    = cntWidth(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_nextState;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_count;
    logic             r_cout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    logic             w_bitSum;
    logic             w_stageCarry;
    logic             w_lastBit;
    logic             w_accept;
    logic [WIDTH-1:0] w_sumShift;

    // The only arithmetic in the design: one full adder fed by the operand
    // LSBs and the carry flip-flop.
    full_adder u_stage (
        .A    (r_sa[0]),
        .B    (r_sb[0]),
        .Cin  (r_carry),
        .Sum  (w_bitSum),
        .Cout (w_stageCarry)
    );

    assign w_lastBit = (r_count == LAST_BIT);
    assign w_accept  = ((r_state == IDLE) || (r_state == DONE)) && bus.start;

    // New bit enters at the MSB so that after WIDTH shifts bit 0 lands in
    // position 0; a one-bit register simply takes the new bit.
    generate
        if (WIDTH == 1) begin : g_sumOneBit
            assign w_sumShift = w_bitSum;
        end else begin : g_sumMultiBit
            assign w_sumShift = {w_bitSum, r_sum[WIDTH-1:1]};
        end
    endgenerate

    // State register; reset returns to IDLE from anywhere, aborting a run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: start is honoured only outside RUN, and RUN ends on
    // the edge that processes the final bit.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                w_nextState = bus.start ? RUN : IDLE;
            end
            RUN: begin
                if (w_lastBit) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = bus.start ? RUN : IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: load operands on acceptance, shift one bit per RUN edge and
    // capture cout/ovf on the last bit. Results are left untouched outside
    // RUN so they stay stable until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_count <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_sa    <= bus.a;
            r_sb    <= bus.b;
            r_carry <= bus.cin;
            r_count <= '0;
        end else if (r_state == RUN) begin
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_sum   <= w_sumShift;
            r_carry <= w_stageCarry;
            r_count <= r_count + CNT_W'(1);
            if (w_lastBit) begin
                r_cout <= w_stageCarry;
                r_ovf  <= w_stageCarry ^ r_carry;
            end
        end
    end

    // Status flags are registered from the next state so busy and done come
    // straight from flops with no path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_nextState == RUN);
            r_done <= (w_nextState == DONE);
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: an 8-bit and a 1-bit instance share clock and
// reset. Drivers push hand-computed expectations into per-instance queues;
// monitors pop and compare whenever done is seen.
module tb_serial_adder;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    exp_t q8[$];
    exp_t q1[$];
    int   done8  = 0;
    int   done1  = 0;
    int   want8  = 0;
    int   want1  = 0;
    int   busy8  = 0;
    int   busy1  = 0;

    // Free-running clock and edge counter used to check done latency.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Issue one operation in the current cycle (called just after a rising
    // edge); the expected result and done cycle go onto the scoreboard.
    task automatic applyStimulus(input bit w1, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin,
                                 input logic [7:0] eSum, input logic eCout,
                                 input logic eOvf);
        exp_t e;
        e.sum  = eSum;
        e.cout = eCout;
        e.ovf  = eOvf;
        e.cyc  = cyc + 1 + (w1 ? 1 : 8);
        if (w1) begin
            if1.start = 1'b1;
            if1.a     = a[0];
            if1.b     = b[0];
            if1.cin   = cin;
            q1.push_back(e);
        end else begin
            if8.start = 1'b1;
            if8.a     = a;
            if8.b     = b;
            if8.cin   = cin;
            q8.push_back(e);
        end
        @(posedge clk);
        #1;
        if1.start = 1'b0;
        if8.start = 1'b0;
    endtask

    // Advance until done is visible; a missing done is a failed check.
    task automatic waitDone(input bit w1);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = w1 ? if1.done : if8.done;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL done timeout (w1=%0d): got no done, expected done", w1);
        end
    endtask

    // 8-bit monitor: checks busy length, result fields and done timing.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy8 = 0;
        end else begin
            if (if8.busy) busy8++;
            if (if8.done) begin
                done8++;
                checkOutput("w8 busy at done", 32'(if8.busy), 32'd0);
                checkOutput("w8 busy length", busy8, 32'd8);
                busy8 = 0;
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL w8 unexpected done: got done, expected none");
                end else begin
                    e = q8.pop_front();
                    checkOutput("w8 sum", 32'(if8.sum), 32'(e.sum));
                    checkOutput("w8 cout", 32'(if8.cout), 32'(e.cout));
                    checkOutput("w8 ovf", 32'(if8.ovf), 32'(e.ovf));
                    checkOutput("w8 done cycle", cyc, e.cyc);
                end
            end
        end
    end

    // 1-bit monitor: same checks for the single-edge RUN case.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy1 = 0;
        end else begin
            if (if1.busy) busy1++;
            if (if1.done) begin
                done1++;
                checkOutput("w1 busy length", busy1, 32'd1);
                busy1 = 0;
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL w1 unexpected done: got done, expected none");
                end else begin
                    e = q1.pop_front();
                    checkOutput("w1 sum", 32'(if1.sum), 32'(e.sum));
                    checkOutput("w1 cout", 32'(if1.cout), 32'(e.cout));
                    checkOutput("w1 ovf", 32'(if1.ovf), 32'(e.ovf));
                    checkOutput("w1 done cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        logic [5:0] tt [8];
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] r9;
        logic       rOvf;

        tt[0] = 6'b000_000;
        tt[1] = 6'b001_101;
        tt[2] = 6'b010_100;
        tt[3] = 6'b011_010;
        tt[4] = 6'b100_100;
        tt[5] = 6'b101_010;
        tt[6] = 6'b110_011;
        tt[7] = 6'b111_110;

        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset w8 busy", 32'(if8.busy), 32'd0);
        checkOutput("reset w8 done", 32'(if8.done), 32'd0);
        checkOutput("reset w8 sum", 32'(if8.sum), 32'd0);
        checkOutput("reset w8 cout", 32'(if8.cout), 32'd0);
        checkOutput("reset w8 ovf", 32'(if8.ovf), 32'd0);
        checkOutput("reset w1 busy", 32'(if1.busy), 32'd0);
        checkOutput("reset w1 done", 32'(if1.done), 32'd0);
        checkOutput("reset w1 sum", 32'(if1.sum), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic add with signed overflow, then results held through idle.
        applyStimulus(0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        waitDone(0);
        want8++;
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("held sum", 32'(if8.sum), 32'h8D);
        checkOutput("held cout", 32'(if8.cout), 32'd0);
        checkOutput("held ovf", 32'(if8.ovf), 32'd1);
        checkOutput("held busy", 32'(if8.busy), 32'd0);

        // Unsigned wrap, then a back-to-back start in the done cycle.
        applyStimulus(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        waitDone(0);
        applyStimulus(0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1);
        waitDone(0);
        want8 += 2;
        @(posedge clk); #1;

        // start and operand changes while busy must be ignored.
        applyStimulus(0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);
        @(posedge clk); #1;
        if8.start = 1'b1; if8.a = 8'hF0; if8.b = 8'hF0; if8.cin = 1'b1;
        @(posedge clk); #1;
        if8.start = 1'b0;
        waitDone(0);
        want8++;
        repeat (3) begin @(posedge clk); #1; end

        // Reset three edges into RUN aborts without a done pulse.
        applyStimulus(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        void'(q8.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("abort busy", 32'(if8.busy), 32'd0);
        checkOutput("abort done", 32'(if8.done), 32'd0);
        checkOutput("abort sum", 32'(if8.sum), 32'd0);
        checkOutput("abort cout", 32'(if8.cout), 32'd0);
        repeat (12) begin @(posedge clk); #1; end
        checkOutput("abort done count", done8, want8);

        // One-bit instance over the whole full-adder truth table.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, {7'd0, tt[i][5]}, {7'd0, tt[i][4]}, tt[i][3],
                          {7'd0, tt[i][2]}, tt[i][1], tt[i][0]);
            waitDone(1);
            want1++;
        end
        @(posedge clk); #1;

        // Random sweep with a bench-side arithmetic model, issued back-to-back.
        for (int i = 0; i < 1000; i++) begin
            ra   = 8'($urandom_range(0, 255));
            rb   = 8'($urandom_range(0, 255));
            rc   = 1'($urandom_range(0, 1));
            r9   = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            rOvf = (ra[7] == rb[7]) && (r9[7] != ra[7]);
            applyStimulus(0, ra, rb, rc, r9[7:0], r9[8], rOvf);
            waitDone(0);
            want8++;
        end

        repeat (4) begin @(posedge clk); #1; end
        checkOutput("w8 done count", done8, want8);
        checkOutput("w1 done count", done1, want1);
        checkOutput("w8 queue drained", q8.size(), 32'd0);
        checkOutput("w1 queue drained", q1.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial, LSB-first adder that adds two WIDTH-bit operands plus a carry-in over WIDTH clock cycles, using a single one-bit full-adder stage and a carry flip-flop. It is the additive counterpart of the existing full-subtractor cells. It sits beside them in the arithmetic library as the area-minimal sequential adder for multi-bit operands. Control is a start/busy/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is not busy.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result, A + B + cin modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow, defined as the carry into the MSB XOR cout.

## Operation
- FSM states are IDLE, RUN and DONE. Reset state is IDLE.
- **IDLE or DONE, start=1:**
  - a, b and cin are loaded into shift registers sa, sb and the carry FF.
  - The bit counter is cleared to 0.
  - The state goes to RUN.
- **IDLE or DONE, start=0:** the state goes to IDLE, or stays there.
- **RUN, each edge:**
  - One bit-sum is computed from sa[0], sb[0] and the carry FF.
  - The bit-sum is shifted into the MSB of the sum shift register, which shifts right.
  - sa and sb shift right.
  - The carry FF is updated with the stage carry.
  - The counter increments.
- **RUN, edge that processes bit WIDTH-1:**
  - The state goes to DONE.
  - cout is set to the stage carry.
  - ovf is set to the stage carry XOR the carry FF value before this edge.
- start is ignored in RUN. Operands are never re-sampled mid-operation.
- The sum/cout/ovf contents are defined only once done has pulsed; before that they must not be used.
- sum, cout and ovf are held from DONE until the next accepted start. They stay stable through the following IDLE cycles.
- Arithmetic is unsigned modulo 2^WIDTH. cout indicates unsigned wrap; ovf indicates signed overflow.
- **WIDTH=1:** RUN lasts exactly one edge, and ovf equals cin XOR cout.

## Timing
- **Reset values:** busy=0, done=0, sum=0, cout=0, ovf=0. The state is IDLE, the counter is 0 and the carry FF is 0.
- rst asserted in any state, including mid-RUN, aborts the operation. All reset values apply on that edge and no done pulse is produced.
- Let edge E be the edge that samples start=1:
  - busy is high for WIDTH cycles, from after E through the edge E+WIDTH.
  - done is high for exactly one cycle, after edge E+WIDTH.
  - The result is valid in that same cycle.
- Latency is WIDTH cycles from start acceptance to done. Throughput is one operation per WIDTH+1 cycles. Back-to-back operation is allowed by asserting start during the done cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package:
  - FSM state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - The counter-width function, clog2(WIDTH) with a minimum of 1.
- One sub-module, full_adder: combinational, with ports A, B, Cin in and Sum, Cout out. It mirrors the existing full-subtractor cells and is instantiated once as the serial stage.
- The top level holds the FSM, the shift registers, the carry FF and the counter.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, cin=0 -> done 8 cycles after acceptance, with sum=0x8D, cout=0, ovf=1.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 issued in the done cycle -> sum=0x80, cout=0, ovf=1, with no idle gap.
- start pulsed, and a/b changed, while busy -> ignored. The original result is delivered and only one done pulse occurs.
- rst asserted 3 cycles into RUN -> busy=0, done=0, sum=0, cout=0 on the next cycle, and no done pulse afterwards.
- WIDTH=1, all 8 combinations of a/b/cin -> sum and cout match the full-adder truth table (e.g. 1,1,1 -> 1,1), with ovf=cin^cout.
- Random sweep, WIDTH=8, 1000 operations -> {cout,sum} equals a+b+cin for every operation, and done occurs exactly once per accepted start.
